// File: rtl/reg_map_regs.sv
// reg_map_regs: 64-word bit-masked register map target with write-response
// handshake, registered read port and decoded control field outputs.
// Optional feature macro: REG_MAP_WR_COUNT_EN (address DEPTH-2 becomes a
// read-only 16-bit count of successful writes).
module reg_map_regs #(
    parameter int unsigned DEPTH     = 64,
    parameter logic [31:0] VERSION   = 32'h0001_0000,
    parameter logic [31:0] CHIRP_RST = 32'd10
) (
    input  logic        aclk,
    input  logic        areset,
    input  logic        reg_map_wr_cmd,
    input  logic [7:0]  reg_map_wr_addr,
    input  logic [31:0] reg_map_wr_data,
    input  logic [31:0] reg_map_wr_keep,
    output logic        reg_map_wr_valid,
    output logic        reg_map_wr_ready,
    output logic [1:0]  reg_map_wr_err,
    input  logic        rd_en,
    input  logic [7:0]  rd_addr,
    output logic [31:0] rd_data,
    output logic        rd_valid,
    output logic [31:0] chirp_period,
    output logic        ddc_duc_bypass,
    output logic        adc_pkt_en,
    output logic [1:0]  mac_speed
);

    localparam int unsigned AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [8:0]  DEPTH_W  = 9'(DEPTH);
    localparam logic [7:0]  ADDR_VER = 8'(DEPTH - 1);
`ifdef REG_MAP_WR_COUNT_EN
    localparam logic [7:0]  ADDR_CNT = 8'(DEPTH - 2);
`endif

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_COMMIT = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        w_commit;
    logic [1:0]  w_err;

    logic [7:0]  r_addr;
    logic [31:0] r_data;
    logic [31:0] r_keep;
    logic        r_ready;
    logic        r_valid;
    logic [1:0]  r_err;
    logic [31:0] r_rd_data;
    logic        r_rd_valid;
    logic [31:0] r_mem [DEPTH];
`ifdef REG_MAP_WR_COUNT_EN
    logic [15:0] r_wr_count;
`endif

    // Error code of the captured command, priority 01 > 10 > 11
    always_comb begin
        w_err = 2'b00;
        if ({1'b0, r_addr} >= DEPTH_W) begin
            w_err = 2'b01;
        end else if (r_addr == ADDR_VER) begin
            w_err = 2'b10;
`ifdef REG_MAP_WR_COUNT_EN
        end else if (r_addr == ADDR_CNT) begin
            w_err = 2'b10;
`endif
        end else if (r_keep == 32'h0) begin
            w_err = 2'b11;
        end
    end

    // Write FSM state register
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Write FSM next state and commit strobe
    always_comb begin
        w_state_nxt = r_state;
        w_commit    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (reg_map_wr_cmd) begin
                    w_state_nxt = S_COMMIT;
                end
            end
            S_COMMIT: begin
                w_commit    = (w_err == 2'b00);
                w_state_nxt = S_RESP;
            end
            S_RESP: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Capture the command only when accepted in IDLE
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_addr <= 8'h0;
            r_data <= 32'h0;
            r_keep <= 32'h0;
        end else if (r_state == S_IDLE && reg_map_wr_cmd) begin
            r_addr <= reg_map_wr_addr;
            r_data <= reg_map_wr_data;
            r_keep <= reg_map_wr_keep;
        end
    end

    // Registered handshake outputs derived from the next state
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_ready <= 1'b1;
            r_valid <= 1'b0;
            r_err   <= 2'b00;
        end else begin
            r_ready <= (w_state_nxt == S_IDLE);
            r_valid <= (w_state_nxt == S_RESP);
            if (r_state == S_COMMIT) begin
                r_err <= w_err;
            end
        end
    end

    // Register file with reset values and masked write at the COMMIT edge
    always_ff @(posedge aclk) begin
        if (areset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (i == 0) begin
                    r_mem[AW'(i)] <= CHIRP_RST;
                end else if (i == 32'h23) begin
                    r_mem[AW'(i)] <= 32'h2;
                end else begin
                    r_mem[AW'(i)] <= 32'h0;
                end
            end
        end else if (w_commit) begin
            r_mem[r_addr[AW-1:0]] <= (r_mem[r_addr[AW-1:0]] & ~r_keep) | (r_data & r_keep);
        end
    end

`ifdef REG_MAP_WR_COUNT_EN
    // Count of successful writes, wraps at 16 bits
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_wr_count <= 16'h0;
        end else if (w_commit) begin
            r_wr_count <= 16'(r_wr_count + 16'd1);
        end
    end
`endif

    // Single-cycle read port; reads at the commit edge see the old value
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_rd_valid <= 1'b0;
            r_rd_data  <= 32'h0;
        end else begin
            r_rd_valid <= rd_en;
            if (rd_en) begin
                if ({1'b0, rd_addr} >= DEPTH_W) begin
                    r_rd_data <= 32'h0;
                end else if (rd_addr == ADDR_VER) begin
                    r_rd_data <= VERSION;
`ifdef REG_MAP_WR_COUNT_EN
                end else if (rd_addr == ADDR_CNT) begin
                    r_rd_data <= {16'h0, r_wr_count};
`endif
                end else begin
                    r_rd_data <= r_mem[rd_addr[AW-1:0]];
                end
            end
        end
    end

    assign reg_map_wr_ready = r_ready;
    assign reg_map_wr_valid = r_valid;
    assign reg_map_wr_err   = r_err;
    assign rd_data          = r_rd_data;
    assign rd_valid         = r_rd_valid;

    // Control fields come straight from storage
    assign chirp_period   = r_mem[0];
    assign ddc_duc_bypass = r_mem[16][0];
    assign adc_pkt_en     = r_mem[32][0];
    assign mac_speed      = r_mem[35][1:0];

endmodule

// File: tb/tb_reg_map_regs.sv
// Scoreboard bench for reg_map_regs: randomized writes/reads against an
// array-based reference model, plus directed boundary and reset cases.
module tb_reg_map_regs;

    localparam int unsigned DEPTH     = 64;
    localparam logic [31:0] VERSION   = 32'h0001_0000;
    localparam logic [31:0] CHIRP_RST = 32'd10;

    logic        aclk = 1'b0;
    logic        areset;
    logic        reg_map_wr_cmd;
    logic [7:0]  reg_map_wr_addr;
    logic [31:0] reg_map_wr_data;
    logic [31:0] reg_map_wr_keep;
    logic        reg_map_wr_valid;
    logic        reg_map_wr_ready;
    logic [1:0]  reg_map_wr_err;
    logic        rd_en;
    logic [7:0]  rd_addr;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic [31:0] chirp_period;
    logic        ddc_duc_bypass;
    logic        adc_pkt_en;
    logic [1:0]  mac_speed;

    always #5 aclk = ~aclk;

    reg_map_regs #(.DEPTH(DEPTH), .VERSION(VERSION), .CHIRP_RST(CHIRP_RST)) dut (
        .aclk(aclk), .areset(areset),
        .reg_map_wr_cmd(reg_map_wr_cmd), .reg_map_wr_addr(reg_map_wr_addr),
        .reg_map_wr_data(reg_map_wr_data), .reg_map_wr_keep(reg_map_wr_keep),
        .reg_map_wr_valid(reg_map_wr_valid), .reg_map_wr_ready(reg_map_wr_ready),
        .reg_map_wr_err(reg_map_wr_err),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
        .chirp_period(chirp_period), .ddc_duc_bypass(ddc_duc_bypass),
        .adc_pkt_en(adc_pkt_en), .mac_speed(mac_speed)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model
    logic [31:0] model_mem [DEPTH];
    logic [15:0] model_cnt;
    logic [1:0]  wq [$];
    logic [31:0] rq [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < int'(DEPTH); i++) model_mem[i] = 32'h0;
        model_mem[0]     = CHIRP_RST;
        model_mem['h23]  = 32'h2;
        model_cnt        = 16'h0;
    endtask

    function automatic logic [1:0] model_err(input logic [7:0] a, input logic [31:0] k);
        if (32'(a) >= DEPTH) return 2'b01;
        if (32'(a) == DEPTH - 1) return 2'b10;
`ifdef REG_MAP_WR_COUNT_EN
        if (32'(a) == DEPTH - 2) return 2'b10;
`endif
        if (k == 32'h0) return 2'b11;
        return 2'b00;
    endfunction

    function automatic logic [31:0] model_read(input logic [7:0] a);
        if (32'(a) >= DEPTH) return 32'h0;
        if (32'(a) == DEPTH - 1) return VERSION;
`ifdef REG_MAP_WR_COUNT_EN
        if (32'(a) == DEPTH - 2) return {16'h0, model_cnt};
`endif
        return model_mem[a[5:0]];
    endfunction

    // Monitor: pops the scoreboard whenever the DUT presents a response
    always @(negedge aclk) begin
        logic [1:0]  e;
        logic [31:0] d;
        if (reg_map_wr_valid === 1'b1) begin
            if (wq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL wr_valid_unexpected actual=1 required=0 at %0t", $time);
            end else begin
                e = wq.pop_front();
                check("wr_err", 32'(reg_map_wr_err), 32'(e));
            end
        end
        if (rd_valid === 1'b1) begin
            if (rq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL rd_valid_unexpected actual=1 required=0 at %0t", $time);
            end else begin
                d = rq.pop_front();
                check("rd_data", rd_data, d);
            end
        end
    end

    task automatic check_fields();
        check("chirp_period", chirp_period, model_mem[0]);
        check("ddc_duc_bypass", 32'(ddc_duc_bypass), 32'(model_mem[16][0]));
        check("adc_pkt_en", 32'(adc_pkt_en), 32'(model_mem[32][0]));
        check("mac_speed", 32'(mac_speed), 32'(model_mem['h23][1:0]));
    endtask

    task automatic rd_exp(input logic [7:0] a, input logic [31:0] exp);
        @(negedge aclk);
        rd_en   = 1'b1;
        rd_addr = a;
        rq.push_back(exp);
    endtask

    task automatic rd_model(input logic [7:0] a);
        rd_exp(a, model_read(a));
    endtask

    task automatic rd_stop();
        @(negedge aclk);
        rd_en = 1'b0;
    endtask

    // One write transaction; optionally spams cmd while busy and/or reads
    // the target address during the commit cycle
    task automatic do_write(input logic [7:0] a, input logic [31:0] d, input logic [31:0] k,
                            input bit spam, input bit rd_commit);
        logic [1:0] e;
        e = model_err(a, k);
        @(negedge aclk);
        check("ready_before", 32'(reg_map_wr_ready), 32'd1);
        reg_map_wr_cmd  = 1'b1;
        reg_map_wr_addr = a;
        reg_map_wr_data = d;
        reg_map_wr_keep = k;
        wq.push_back(e);
        @(negedge aclk);
        check("ready_cycle1", 32'(reg_map_wr_ready), 32'd0);
        check("valid_cycle1", 32'(reg_map_wr_valid), 32'd0);
        if (spam) begin
            reg_map_wr_addr = 8'h00;
            reg_map_wr_data = ~d;
            reg_map_wr_keep = 32'hFFFF_FFFF;
        end else begin
            reg_map_wr_cmd = 1'b0;
        end
        if (rd_commit) begin
            rd_en   = 1'b1;
            rd_addr = a;
            rq.push_back(model_read(a));
        end
        @(negedge aclk);
        rd_en = 1'b0;
        check("ready_cycle2", 32'(reg_map_wr_ready), 32'd0);
        check("valid_cycle2", 32'(reg_map_wr_valid), 32'd1);
        if (e == 2'b00) begin
            model_mem[a[5:0]] = (model_mem[a[5:0]] & ~k) | (d & k);
            model_cnt         = model_cnt + 16'd1;
        end
        check_fields();
        @(negedge aclk);
        reg_map_wr_cmd = 1'b0;
        check("ready_after", 32'(reg_map_wr_ready), 32'd1);
        check("valid_after", 32'(reg_map_wr_valid), 32'd0);
    endtask

    task automatic do_reset();
        areset = 1'b1;
        repeat (3) @(negedge aclk);
        areset = 1'b0;
        model_reset();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  a;
        logic [31:0] k;
        int unsigned r;

        areset          = 1'b1;
        reg_map_wr_cmd  = 1'b0;
        reg_map_wr_addr = 8'h0;
        reg_map_wr_data = 32'h0;
        reg_map_wr_keep = 32'h0;
        rd_en           = 1'b0;
        rd_addr         = 8'h0;
        do_reset();

        // Reset state
        check("rst_ready", 32'(reg_map_wr_ready), 32'd1);
        check("rst_valid", 32'(reg_map_wr_valid), 32'd0);
        check("rst_err", 32'(reg_map_wr_err), 32'd0);
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        check("rst_rd_data", rd_data, 32'h0);
        check("rst_chirp", chirp_period, 32'd10);
        check("rst_mac_speed", 32'(mac_speed), 32'd2);
        rd_exp(8'h00, 32'd10);
        rd_exp(8'h23, 32'd2);
        rd_exp(8'(DEPTH - 1), VERSION);
        rd_exp(8'hC5, 32'h0);
        rd_stop();

        // Directed writes
        do_write(8'h20, 32'h1, 32'h1, 1'b0, 1'b0);
        check("adc_pkt_en_set", 32'(adc_pkt_en), 32'd1);
        do_write(8'h00, 32'hFFFF_FFFF, 32'h0000_FF00, 1'b0, 1'b0);
        rd_exp(8'h00, 32'h0000_FF0A);
        rd_stop();
        do_write(8'h80, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 1'b0, 1'b0);
        do_write(8'(DEPTH - 1), 32'hDEAD_BEEF, 32'hFFFF_FFFF, 1'b0, 1'b0);
        do_write(8'h05, 32'hDEAD_BEEF, 32'h0, 1'b0, 1'b0);
        rd_exp(8'h05, 32'h0);
        rd_exp(8'(DEPTH - 1), VERSION);
        rd_stop();
        do_write(8'h10, 32'h1, 32'h1, 1'b1, 1'b1);
        rd_model(8'h00);
        rd_model(8'h10);
        rd_stop();

        // Randomized traffic
        for (int i = 0; i < 160; i++) begin
            r = $urandom_range(0, 9);
            if (r == 0)      a = 8'($urandom_range(64, 255));
            else if (r == 1) a = 8'(DEPTH - 1);
            else if (r == 2) a = 8'(DEPTH - 2);
            else if (r == 3) a = 8'h00;
            else if (r == 4) a = 8'h23;
            else if (r == 5) a = ($urandom_range(0, 1) == 1) ? 8'h10 : 8'h20;
            else             a = 8'($urandom_range(0, 63));
            k = ($urandom_range(0, 7) == 0) ? 32'h0 : 32'($urandom);
            do_write(a, 32'($urandom), k, $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0);
            if ($urandom_range(0, 1) == 1) begin
                rd_model(8'($urandom_range(0, 80)));
                rd_model(a);
                rd_stop();
            end
        end

        // Abort during COMMIT
        @(negedge aclk);
        reg_map_wr_cmd  = 1'b1;
        reg_map_wr_addr = 8'h10;
        reg_map_wr_data = 32'h1;
        reg_map_wr_keep = 32'h1;
        @(negedge aclk);
        reg_map_wr_cmd = 1'b0;
        areset         = 1'b1;
        @(negedge aclk);
        areset = 1'b0;
        model_reset();
        check("abort_ready", 32'(reg_map_wr_ready), 32'd1);
        check("abort_valid", 32'(reg_map_wr_valid), 32'd0);
        for (int i = 0; i < int'(DEPTH); i++) rd_model(8'(i));
        rd_stop();
        check_fields();

`ifdef REG_MAP_WR_COUNT_EN
        do_write(8'h01, 32'h11, 32'hFF, 1'b0, 1'b0);
        do_write(8'h02, 32'h22, 32'hFF, 1'b0, 1'b0);
        do_write(8'h03, 32'h33, 32'hFF, 1'b0, 1'b0);
        do_write(8'(DEPTH - 2), 32'h44, 32'hFF, 1'b0, 1'b0);
        rd_exp(8'(DEPTH - 2), 32'd3);
        rd_stop();
`endif

        repeat (4) @(negedge aclk);
        check("wr_queue_drained", 32'(wq.size()), 32'd0);
        check("rd_queue_drained", 32'(rq.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
